// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell and a carry flop, LSB first.
// start/busy/done handshake; sum/cout/ovf update only when the result is complete.
module serial_adder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_res;
  logic           r_c;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_sum;
  logic           r_cout;
  logic           r_ovf;

  logic           w_s;
  logic           w_c_nxt;
  logic           w_last;
  logic           w_load;
  logic [N-1:0]   w_res_nxt;

  assign w_s     = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c_nxt = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last  = (r_cnt == CW'(N - 1));

  // New sum bit enters at the MSB; after N shifts bit i sits at position i.
  assign w_res_nxt = (r_res >> 1) | (N'(w_s) << (N - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
      if (w_load) begin
        r_a   <= a;
        r_b   <= b;
        r_c   <= cin;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_c   <= w_c_nxt;
        r_cnt <= r_cnt + CW'(1);
        r_res <= w_res_nxt;
        // On the last bit r_c is the carry into the MSB.
        if (w_last) begin
          r_sum  <= w_res_nxt;
          r_cout <= w_c_nxt;
          r_ovf  <= r_c ^ w_c_nxt;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
